// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared selector encodings and stage metadata for forwarding_hazard_unit
//
// Contents:
//   FWD_REGFILE / FWD_MEMWB / FWD_EXMEM  operand-mux select encodings (2'd3 is reserved)
//   FWD_ADDR_W                           width of the dst field carried in stage_meta_t
//   stage_meta_t                         per-stage destination metadata (dst, regwrite, memread)
//   STAGE_BUBBLE                         metadata of an inserted bubble (never matches anything)
//   is_writer()                          true when a stage will really update the register file
package fwd_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEMWB   = 2'd1;
  localparam logic [1:0] FWD_EXMEM   = 2'd2;

  // Address fields inside stage_meta_t are this wide; the top-level
  // REG_ADDR_W must not exceed it.
  localparam int FWD_ADDR_W = 5;

  typedef struct packed {
    logic [FWD_ADDR_W-1:0] dst;
    logic                  regwrite;
    logic                  memread;
  } stage_meta_t;

  localparam stage_meta_t STAGE_BUBBLE = '{dst: '0, regwrite: 1'b0, memread: 1'b0};

  // Writes to $0 are architecturally discarded, so they are never a
  // forwarding source nor a load-use hazard.
  function automatic logic is_writer(input stage_meta_t s);
    return s.regwrite && (s.dst != '0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding priority comparator
//
// Pure combinational. One instance per ALU operand.
// Ports:
//   ex_use        in   consumer in EX actually reads this operand
//   ex_src        in   consumer's source register for this operand
//   mem_regwrite  in   instruction in MEM writes the register file
//   mem_dst       in   destination of the instruction in MEM
//   wb_regwrite   in   instruction in WB writes the register file
//   wb_dst        in   destination of the instruction in WB
//   sel           out  FWD_EXMEM / FWD_MEMWB / FWD_REGFILE
module fwd_select
  import fwd_pkg::*;
#(
  parameter int W = FWD_ADDR_W
) (
  input  logic         ex_use,
  input  logic [W-1:0] ex_src,
  input  logic         mem_regwrite,
  input  logic [W-1:0] mem_dst,
  input  logic         wb_regwrite,
  input  logic [W-1:0] wb_dst,
  output logic [1:0]   sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_regwrite && (mem_dst != '0) && ex_use && (mem_dst == ex_src);
    wb_hit  = wb_regwrite  && (wb_dst  != '0) && ex_use && (wb_dst  == ex_src);
    sel     = FWD_REGFILE;
    // The MEM-stage result is younger than the WB one, so it wins a tie.
    if (mem_hit) begin
      sel = FWD_EXMEM;
    end else if (wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - forwarding selectors and load-use stall for a 5-stage MIPS pipe
//
// Keeps shadow copies of the EX/MEM/WB register metadata and derives the
// ALU operand-mux selects plus a one-cycle load-use stall request.
// Optional statistics counters are built when FWD_STATS_EN is defined.
// Parameters:
//   REG_ADDR_W  register-file address width (<= fwd_pkg::FWD_ADDR_W)
//   CNT_W       statistics counter width (exists only with FWD_STATS_EN)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      ID source registers
//   id_use_rs/_rt     ID instruction reads rs / rt
//   id_dst            ID destination (rt/rd already resolved)
//   id_regwrite       ID instruction writes the register file
//   id_memread        ID instruction is a load
//   flush             squash the ID instruction
//   hold              freeze the whole pipeline
//   fwd_a_sel/_b_sel  operand mux selects (0 regfile, 1 MEM/WB, 2 EX/MEM)
//   stall             hold PC and IF/ID this cycle
//   stall_count       (FWD_STATS_EN) saturating count of stall cycles
//   fwd_count         (FWD_STATS_EN) saturating count of forwarding cycles
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef FWD_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  input  logic                  hold,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      fwd_count
`endif
);

  // EX stage: destination metadata plus the consumer-side source fields.
  stage_meta_t           ex_q;
  logic [REG_ADDR_W-1:0] ex_rs_q;
  logic [REG_ADDR_W-1:0] ex_rt_q;
  logic                  ex_use_rs_q;
  logic                  ex_use_rt_q;

  // MEM and WB only need to be known as producers.
  logic [REG_ADDR_W-1:0] mem_dst_q;
  logic                  mem_regwrite_q;
  logic [REG_ADDR_W-1:0] wb_dst_q;
  logic                  wb_regwrite_q;

  logic [REG_ADDR_W-1:0] ex_dst;
  logic                  load_use;
  logic                  ex_take_id;

  assign ex_dst = REG_ADDR_W'(ex_q.dst);

  always_comb begin
    load_use = ex_q.memread && is_writer(ex_q) && id_valid &&
               ((id_use_rs && (id_rs == ex_dst)) ||
                (id_use_rt && (id_rt == ex_dst)));
    // A taken branch discards the consumer anyway, and a frozen pipe
    // cannot advance, so neither needs the extra bubble.
    stall      = load_use && !flush && !hold;
    ex_take_id = id_valid && !stall && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= STAGE_BUBBLE;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_use_rs_q    <= 1'b0;
      ex_use_rt_q    <= 1'b0;
      mem_dst_q      <= '0;
      mem_regwrite_q <= 1'b0;
      wb_dst_q       <= '0;
      wb_regwrite_q  <= 1'b0;
    end else if (!hold) begin
      wb_dst_q       <= mem_dst_q;
      wb_regwrite_q  <= mem_regwrite_q;
      mem_dst_q      <= ex_dst;
      mem_regwrite_q <= ex_q.regwrite;
      if (ex_take_id) begin
        ex_q        <= '{dst: FWD_ADDR_W'(id_dst), regwrite: id_regwrite, memread: id_memread};
        ex_rs_q     <= id_rs;
        ex_rt_q     <= id_rt;
        ex_use_rs_q <= id_use_rs;
        ex_use_rt_q <= id_use_rt;
      end else begin
        // Bubble: every flag cleared so it can neither produce nor consume.
        ex_q        <= STAGE_BUBBLE;
        ex_rs_q     <= '0;
        ex_rt_q     <= '0;
        ex_use_rs_q <= 1'b0;
        ex_use_rt_q <= 1'b0;
      end
    end
  end

  fwd_select #(
    .W (REG_ADDR_W)
  ) u_sel_a (
    .ex_use       (ex_use_rs_q),
    .ex_src       (ex_rs_q),
    .mem_regwrite (mem_regwrite_q),
    .mem_dst      (mem_dst_q),
    .wb_regwrite  (wb_regwrite_q),
    .wb_dst       (wb_dst_q),
    .sel          (fwd_a_sel)
  );

  fwd_select #(
    .W (REG_ADDR_W)
  ) u_sel_b (
    .ex_use       (ex_use_rt_q),
    .ex_src       (ex_rt_q),
    .mem_regwrite (mem_regwrite_q),
    .mem_dst      (mem_dst_q),
    .wb_regwrite  (wb_regwrite_q),
    .wb_dst       (wb_dst_q),
    .sel          (fwd_b_sel)
  );

`ifdef FWD_STATS_EN
  logic fwd_active;

  assign fwd_active = (fwd_a_sel != FWD_REGFILE) || (fwd_b_sel != FWD_REGFILE);

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (!hold && fwd_active && (fwd_count != '1)) begin
        fwd_count <= fwd_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - self-checking bench for forwarding_hazard_unit
module tb_forwarding_hazard_unit;

  localparam int TB_CNT_W = 6;
  localparam int TB_CNT_MAX = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_use_rs = 1'b0;
  logic       id_use_rt = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_regwrite = 1'b0;
  logic       id_memread = 1'b0;
  logic       flush = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [TB_CNT_W-1:0] stall_count;
  logic [TB_CNT_W-1:0] fwd_count;
`endif

  int checks = 0;
  int errors = 0;

`ifdef FWD_STATS_EN
  forwarding_hazard_unit #(.REG_ADDR_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .hold(hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count), .fwd_count(fwd_count)
  );
`else
  forwarding_hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .hold(hold),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
  );
`endif

  always #5 clk = ~clk;

  // Model: list of instructions past ID, youngest first (EX, MEM, WB).
  typedef struct {
    bit rw;
    bit mr;
    bit urs;
    bit urt;
    int rs;
    int rt;
    int dst;
  } ins_t;

  ins_t pipe[$];
  int   m_sc;
  int   m_fc;
  bit   m_st;

  task automatic model_reset();
    ins_t b;
    b = '{rw: 0, mr: 0, urs: 0, urt: 0, rs: 0, rt: 0, dst: 0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(b);
    m_sc = 0;
    m_fc = 0;
  endtask

  // Nearest older writer of the register the EX consumer reads.
  function automatic int exp_sel(bit opb);
    int src;
    bit used;
    src  = opb ? pipe[0].rt : pipe[0].rs;
    used = opb ? pipe[0].urt : pipe[0].urs;
    if (!used) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].rw && pipe[k].dst != 0 && pipe[k].dst == src) return (k == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall();
    int d;
    if (hold || flush || !id_valid) return 0;
    if (!(pipe[0].mr && pipe[0].rw && pipe[0].dst != 0)) return 0;
    d = pipe[0].dst;
    return (id_use_rs && int'(id_rs) == d) || (id_use_rt && int'(id_rt) == d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (!hold) begin
      ins_t n;
      m_st = exp_stall();
      if (m_st && m_sc < TB_CNT_MAX) m_sc++;
      if ((exp_sel(0) != 0 || exp_sel(1) != 0) && m_fc < TB_CNT_MAX) m_fc++;
      if (id_valid && !m_st && !flush)
        n = '{rw: id_regwrite, mr: id_memread, urs: id_use_rs, urt: id_use_rt,
              rs: int'(id_rs), rt: int'(id_rt), dst: int'(id_dst)};
      else
        n = '{rw: 0, mr: 0, urs: 0, urt: 0, rs: 0, rt: 0, dst: 0};
      pipe.push_front(n);
      pipe.delete(3);
    end
  end

  always @(negedge clk) begin
    chk("cyc_fwd_a", 32'(fwd_a_sel), 32'(exp_sel(0)));
    chk("cyc_fwd_b", 32'(fwd_b_sel), 32'(exp_sel(1)));
    chk("cyc_stall", 32'(stall), 32'(exp_stall()));
`ifdef FWD_STATS_EN
    chk("cyc_stall_count", 32'(stall_count), 32'(m_sc));
    chk("cyc_fwd_count", 32'(fwd_count), 32'(m_fc));
`endif
  end

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit mr, input bit fl, input bit hd);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = 5'(dst);
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
    hold        = hd;
  endtask

  task automatic alu(input int rs, input int rt, input int dst);
    drive(1, rs, rt, 1, 1, dst, 1, 0, 0, 0);
  endtask

  task automatic lw(input int rs, input int dst);
    drive(1, rs, 0, 1, 0, dst, 1, 1, 0, 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset_fwd_a", 32'(fwd_a_sel), 0);
    chk("reset_fwd_b", 32'(fwd_b_sel), 0);
    chk("reset_stall", 32'(stall), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back ADD $3 -> SUB $3
    alu(1, 2, 3); tick();
    alu(3, 4, 8); tick();
    chk("t1_fwd_a_exmem", 32'(fwd_a_sel), 2);
    chk("t1_fwd_b_none", 32'(fwd_b_sel), 0);
    chk("t1_stall", 32'(stall), 0);

    // ADD $3, NOP, OR using $3 as rt
    alu(1, 2, 3); tick();
    idle(); tick();
    alu(1, 3, 9); tick();
    chk("t2_fwd_b_memwb", 32'(fwd_b_sel), 1);
    chk("t2_fwd_a_none", 32'(fwd_a_sel), 0);

    // Same with $0: never forwarded
    alu(1, 2, 0); tick();
    idle(); tick();
    alu(1, 0, 9); tick();
    chk("t2_zero_fwd_b", 32'(fwd_b_sel), 0);

    // LW $5 then ADD $5: one stall, bubble, then MEM/WB forward
    lw(0, 5); tick();
    alu(5, 6, 10); #1;
    chk("t3_stall", 32'(stall), 1);
    tick();
    chk("t3_stall_once", 32'(stall), 0);
    chk("t3_bubble_a", 32'(fwd_a_sel), 0);
    tick();
    chk("t3_fwd_a_memwb", 32'(fwd_a_sel), 1);
    chk("t3_no_restall", 32'(stall), 0);

    // LW $5 then ADD $5 with flush in the stall cycle
    lw(0, 5); tick();
    drive(1, 5, 6, 1, 1, 10, 1, 0, 1, 0); #1;
    chk("t4_flush_stall", 32'(stall), 0);
    tick();
    idle();
    chk("t4_flush_a", 32'(fwd_a_sel), 0);
    chk("t4_flush_b", 32'(fwd_b_sel), 0);

    // Two writers of $7, consumer (a load to $8) reads $7 on both operands
    alu(1, 2, 7); tick();
    alu(1, 2, 7); tick();
    drive(1, 7, 7, 1, 1, 8, 1, 1, 0, 0); tick();
    chk("t5_fwd_a_prio", 32'(fwd_a_sel), 2);
    chk("t5_fwd_b_prio", 32'(fwd_b_sel), 2);
    drive(1, 8, 0, 1, 0, 11, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_a", 32'(fwd_a_sel), 2);
      chk("t5_hold_b", 32'(fwd_b_sel), 2);
      chk("t5_hold_stall", 32'(stall), 0);
    end
    drive(1, 8, 0, 1, 0, 11, 1, 0, 0, 0); #1;
    chk("t5_unhold_stall", 32'(stall), 1);
    chk("t5_unhold_a", 32'(fwd_a_sel), 2);

    // Reset mid-stall
    rst_n = 1'b0; #1;
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_a", 32'(fwd_a_sel), 0);
    chk("t6_rst_b", 32'(fwd_b_sel), 0);
    tick(); tick();
    idle();
    rst_n = 1'b1;
    tick();

`ifdef FWD_STATS_EN
    lw(0, 5); tick();
    alu(5, 6, 10); tick(); tick();
    idle(); tick();
    chk("st_stall_count_1", 32'(stall_count), 1);
    chk("st_fwd_count_1", 32'(fwd_count), 1);
    for (int i = 0; i < 70; i++) begin
      lw(0, 5); tick();
      alu(5, 6, 10); tick(); tick();
    end
    idle(); tick();
    chk("st_stall_count_sat", 32'(stall_count), 32'(TB_CNT_MAX));
    chk("st_fwd_count_sat", 32'(fwd_count), 32'(TB_CNT_MAX));
`endif

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
